// File: rtl/panel_pkg.sv
// Shared types for the front-panel sequencer: FSM states and button press events.
package panel_pkg;

    typedef enum logic [2:0] {
        POR   = 3'd0,
        IDLE  = 3'd1,
        RST   = 3'd2,
        CLR   = 3'd3,
        RUN1  = 3'd4,
        HALT1 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } press_t;

endpackage

// File: rtl/panel_sequencer_button_conditioner.sv
// One push-button channel: invert, 2-flop synchronise, debounce, arm, and classify
// short/long presses into a single-cycle press event.
module button_conditioner
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int LONGPRESS_CYCLES = 1024
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   nbut,
    output press_t press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONGPRESS_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONGPRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONGPRESS_CYCLES - 1);

    logic              sync1_r;
    logic              sync2_r;
    logic              level_r;
    logic              armed_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [HOLD_W-1:0] hold_r;
    press_t            press_r;

    logic   flip_s;
    logic   rise_s;
    logic   fall_s;
    press_t press_s;

    // Level flip and event classification; events are registered on the same
    // edge the debounced level changes, keeping release-to-pulse latency short.
    always_comb begin
        flip_s  = 1'b0;
        press_s = NONE;
        if ((sync2_r != level_r) && (db_cnt_r == DB_LAST)) begin
            flip_s = 1'b1;
        end else begin
            flip_s = 1'b0;
        end
        rise_s = flip_s & sync2_r;
        fall_s = flip_s & ~sync2_r;
        if (armed_r && fall_s && (hold_r < HOLD_MAX)) begin
            press_s = SHORT;
        end else if (armed_r && level_r && !flip_s && (hold_r == HOLD_PRE)) begin
            press_s = LONG;
        end else begin
            press_s = NONE;
        end
    end

    // Synchroniser, debouncer, hold counter, arming and event register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            level_r  <= 1'b0;
            armed_r  <= 1'b0;
            db_cnt_r <= '0;
            hold_r   <= '0;
            press_r  <= NONE;
        end else begin
            sync1_r <= ~nbut;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    level_r  <= sync2_r;
                    db_cnt_r <= '0;
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= '0;
            end
            if (rise_s) begin
                hold_r <= '0;
            end else if (level_r && !fall_s && (hold_r < HOLD_MAX)) begin
                hold_r <= hold_r + HOLD_W'(1);
            end
            // A held button stays disarmed until a debounced release is seen.
            if (press_s != NONE) begin
                armed_r <= 1'b0;
            end else if (!level_r) begin
                armed_r <= 1'b1;
            end
            press_r <= press_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/panel_sequencer.sv
// Front-panel sequencer: conditions both buttons and drives the CPU panel switches.
// Optional PANEL_AUTORUN_EN: power-on sequence ends with a run request.
module panel_sequencer
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int LONGPRESS_CYCLES = 1024,
    parameter int RESET_CYCLES     = 4,
    parameter int POR_CYCLES       = 8
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic nBUT1,
    input  logic nBUT2,
    input  logic CPU_RUNNING,
    output logic sw_RUN,
    output logic sw_HALT,
    output logic sw_RESET,
    output logic sw_CLEAR,
    output logic BUSY
);

    localparam int SEQ_MAX = (POR_CYCLES > RESET_CYCLES) ? POR_CYCLES : RESET_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam logic [SEQ_W-1:0] POR_LAST = SEQ_W'(POR_CYCLES - 1);
    localparam logic [SEQ_W-1:0] RST_LAST = SEQ_W'(RESET_CYCLES - 1);

    press_t press1_s;
    press_t press2_s;

    state_t           state_r;
    state_t           state_nx_s;
    logic [SEQ_W-1:0] cnt_r;
    logic [SEQ_W-1:0] cnt_nx_s;
    logic             autorun_r;
    logic             autorun_nx_s;
    logic             sw_run_r;
    logic             sw_halt_r;
    logic             sw_reset_r;
    logic             sw_clear_r;
    logic             busy_r;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
    ) u_but1 (
        .clk  (SYSCLK),
        .reset(RESET),
        .nbut (nBUT1),
        .press(press1_s)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
    ) u_but2 (
        .clk  (SYSCLK),
        .reset(RESET),
        .nbut (nBUT2),
        .press(press2_s)
    );

    // Next-state logic; events outside IDLE are dropped, BUT2 outranks BUT1.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        autorun_nx_s = autorun_r;
        case (state_r)
            POR: begin
                if (cnt_r == POR_LAST) begin
                    state_nx_s = RST;
                    cnt_nx_s   = '0;
`ifdef PANEL_AUTORUN_EN
                    autorun_nx_s = 1'b1;
`else
                    autorun_nx_s = autorun_r;
`endif
                end else begin
                    cnt_nx_s = cnt_r + SEQ_W'(1);
                end
            end
            IDLE: begin
                cnt_nx_s = '0;
                if (press2_s == LONG) begin
                    state_nx_s   = RST;
                    autorun_nx_s = 1'b1;
                end else if (press2_s == SHORT) begin
                    state_nx_s = RST;
                end else if (press1_s == SHORT) begin
                    state_nx_s = CPU_RUNNING ? HALT1 : RUN1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RST: begin
                if (cnt_r == RST_LAST) begin
                    state_nx_s = CLR;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + SEQ_W'(1);
                end
            end
            CLR: begin
                if (autorun_r) begin
                    state_nx_s   = RUN1;
                    autorun_nx_s = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN1:    state_nx_s = IDLE;
            HALT1:   state_nx_s = IDLE;
            default: begin
                state_nx_s   = POR;
                cnt_nx_s     = '0;
                autorun_nx_s = 1'b0;
            end
        endcase
    end

    // State register; outputs are registered from the current state.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_r    <= POR;
            cnt_r      <= '0;
            autorun_r  <= 1'b0;
            sw_run_r   <= 1'b0;
            sw_halt_r  <= 1'b0;
            sw_reset_r <= 1'b0;
            sw_clear_r <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            autorun_r  <= autorun_nx_s;
            sw_run_r   <= (state_r == RUN1);
            sw_halt_r  <= (state_r == HALT1);
            sw_reset_r <= (state_r == RST);
            sw_clear_r <= (state_r == CLR);
            busy_r     <= (state_r != IDLE);
        end
    end

    assign sw_RUN   = sw_run_r;
    assign sw_HALT  = sw_halt_r;
    assign sw_RESET = sw_reset_r;
    assign sw_CLEAR = sw_clear_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_panel_sequencer.sv
// Directed, table-driven bench for panel_sequencer with small debounce/long-press constants.
module tb_panel_sequencer;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic nBUT1 = 1'b1;
    logic nBUT2 = 1'b1;
    logic CPU_RUNNING = 1'b0;
    logic sw_RUN, sw_HALT, sw_RESET, sw_CLEAR, BUSY;

    int tests = 0;
    int failed = 0;
    int n_run = 0, n_halt = 0, n_rst = 0, n_clr = 0, n_viol = 0;

    always #5 clk = ~clk;

    panel_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .LONGPRESS_CYCLES(32),
        .RESET_CYCLES    (4),
        .POR_CYCLES      (8)
    ) dut (
        .SYSCLK     (clk),
        .RESET      (RESET),
        .nBUT1      (nBUT1),
        .nBUT2      (nBUT2),
        .CPU_RUNNING(CPU_RUNNING),
        .sw_RUN     (sw_RUN),
        .sw_HALT    (sw_HALT),
        .sw_RESET   (sw_RESET),
        .sw_CLEAR   (sw_CLEAR),
        .BUSY       (BUSY)
    );

    // Pulse/cycle counters and mutual-exclusion watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!RESET) begin
            n_run  <= n_run + int'(sw_RUN);
            n_halt <= n_halt + int'(sw_HALT);
            n_rst  <= n_rst + int'(sw_RESET);
            n_clr  <= n_clr + int'(sw_CLEAR);
            if ((sw_RUN && sw_HALT) || ((sw_RUN || sw_HALT) && sw_RESET))
                n_viol <= n_viol + 1;
        end
    end

    typedef struct {
        int n1; int n2; bit cpu;
        int e_run; int e_halt; int e_rst; int e_clr;
    } vec_t;
    vec_t vecs[10];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            tick(1);
            if (!BUSY) ok = 1;
        end
        check(name, ok, 1);
    endtask

    initial begin
        int b_run, b_halt, b_rst, b_clr, m, found, rise, busy_drop;
        logic [4:0] got, exp;

        vecs[0] = '{10,  0, 1'b0, 1, 0, 0, 0};
        vecs[1] = '{10,  0, 1'b1, 0, 1, 0, 0};
        vecs[2] = '{10, 10, 1'b0, 0, 0, 4, 1};
        vecs[3] = '{ 0, 10, 1'b1, 0, 0, 4, 1};
        vecs[4] = '{ 3,  0, 1'b0, 0, 0, 0, 0};
        vecs[5] = '{ 4,  0, 1'b0, 1, 0, 0, 0};
        vecs[6] = '{30,  0, 1'b1, 0, 1, 0, 0};
        vecs[7] = '{40,  0, 1'b0, 0, 0, 0, 0};
        vecs[8] = '{ 0, 30, 1'b0, 0, 0, 4, 1};
        vecs[9] = '{ 0, 36, 1'b0, 1, 0, 4, 1};

        // Reset state and cycle-exact power-on sequence.
        RESET = 1'b1;
        tick(3);
        check("reset_state", int'({sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, BUSY}), 1);
        RESET = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            got = {sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, BUSY};
            exp[4] = (k >= 9 && k <= 12);
            exp[3] = (k == 13);
            exp[1] = 1'b0;
`ifdef PANEL_AUTORUN_EN
            exp[2] = (k == 14);
            exp[0] = (k <= 14);
`else
            exp[2] = 1'b0;
            exp[0] = (k <= 13);
`endif
            check($sformatf("por_cycle_%0d", k), int'(got), int'(exp));
        end
        wait_idle("por_idle");

        // Table of button patterns; releases of both buttons are aligned.
        foreach (vecs[v]) begin
            CPU_RUNNING = vecs[v].cpu;
            b_run = n_run; b_halt = n_halt; b_rst = n_rst; b_clr = n_clr;
            m = (vecs[v].n1 > vecs[v].n2) ? vecs[v].n1 : vecs[v].n2;
            for (int c = 0; c < m; c++) begin
                nBUT1 = (c >= m - vecs[v].n1) ? 1'b0 : 1'b1;
                nBUT2 = (c >= m - vecs[v].n2) ? 1'b0 : 1'b1;
                tick(1);
            end
            nBUT1 = 1'b1;
            nBUT2 = 1'b1;
            tick(30);
            wait_idle($sformatf("vec%0d_idle", v));
            check($sformatf("vec%0d_run", v),  n_run  - b_run,  vecs[v].e_run);
            check($sformatf("vec%0d_halt", v), n_halt - b_halt, vecs[v].e_halt);
            check($sformatf("vec%0d_rst", v),  n_rst  - b_rst,  vecs[v].e_rst);
            check($sformatf("vec%0d_clr", v),  n_clr  - b_clr,  vecs[v].e_clr);
        end

        // Bouncing BUT1: low runs of 3 broken by 2-cycle glitches never debounce.
        CPU_RUNNING = 1'b0;
        b_run = n_run; b_halt = n_halt;
        for (int c = 0; c < 10; c++) begin
            nBUT1 = ((c % 5) < 3) ? 1'b0 : 1'b1;
            tick(1);
        end
        nBUT1 = 1'b1;
        tick(30);
        check("bounce_run", n_run - b_run, 0);
        check("bounce_halt", n_halt - b_halt, 0);
        check("bounce_busy", int'(BUSY), 0);

        // Long BUT2 hold fires autorun sequence once; a sub-debounce release re-hold is ignored.
        b_run = n_run; b_rst = n_rst; b_clr = n_clr;
        nBUT2 = 1'b0;
        tick(100);
        check("long_rst_held", n_rst - b_rst, 4);
        check("long_clr_held", n_clr - b_clr, 1);
        check("long_run_held", n_run - b_run, 1);
        nBUT2 = 1'b1;
        tick(2);
        nBUT2 = 1'b0;
        tick(50);
        nBUT2 = 1'b1;
        tick(40);
        check("rehold_rst", n_rst - b_rst, 4);
        check("rehold_run", n_run - b_run, 1);
        check("rehold_busy", int'(BUSY), 0);

        // RESET during the 2nd sw_RESET cycle aborts and restarts power-on.
        nBUT2 = 1'b0;
        tick(10);
        nBUT2 = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(1);
            if (sw_RESET) found = 1;
        end
        check("abort_seen", found, 1);
        tick(1);
        check("abort_second", int'(sw_RESET), 1);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("abort_drop", int'(sw_RESET), 0);
        check("abort_busy", int'(BUSY), 1);
        rise = 0;
        busy_drop = 0;
        for (int k = 1; k <= 12 && rise == 0; k++) begin
            tick(1);
            if (!BUSY) busy_drop = 1;
            if (sw_RESET) rise = k;
        end
        check("abort_por_delay", rise, 9);
        check("abort_busy_hold", busy_drop, 0);
        wait_idle("abort_idle");

        tick(2);
        check("exclusive_outputs", n_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
